cpu_trace_buffer: RTL

Synthesizable instruction-trace capture unit for the GameBoy core. It snoops the datapath at every instruction fetch and records PC, SP, IR, flags and a cycle stamp into a parametrised circular buffer. Capture is armed, triggered (immediately, on a PC match or on an opcode match) and frozen after a programmable post-trigger count. The frozen trace then drains over a valid/ready port to a debug UART or JTAG bridge, replacing console monitoring on hardware.

---
 rtl/trace_pkg.sv | 48 ++++
 rtl/trace_ram.sv | 28 ++
 rtl/cpu_trace_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types for the instruction-trace capture unit
package trace_pkg;

  localparam int TRACE_CYC_W = 32;

  typedef struct packed {
    logic [TRACE_CYC_W-1:0] cycle;
    logic [15:0]            pc;
    logic [15:0]            sp;
    logic [7:0]             ir;
    logic [3:0]             flags;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  typedef enum logic [1:0] {
    TRIG_IMM  = 2'd0,
    TRIG_PC   = 2'd1,
    TRIG_OP   = 2'd2,
    TRIG_NONE = 2'd3
  } trig_mode_t;

  // Readout sub-phases inside DONE: pointer setup, first RAM read, streaming
  typedef enum logic [1:0] {
    RD_SETUP  = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_phase_t;

  function automatic logic trig_hit(input trig_mode_t mode, input logic [15:0] value,
                                    input logic [15:0] fpc, input logic [7:0] fir);
    logic hit;
    hit = 1'b0;
    case (mode)
      TRIG_IMM: hit = 1'b1;
      TRIG_PC:  hit = (fpc == value);
      TRIG_OP:  hit = (fir == value[7:0]);
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port trace storage, registered read port
module trace_ram #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 76,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read register so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - armed/triggered fetch trace capture with valid/ready readout
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int CYC_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  input  logic [15:0]     pc,
  input  logic [15:0]     sp,
  input  logic [7:0]      ir,
  input  logic [3:0]      flags,
  input  logic            arm,
  input  logic [1:0]      trig_mode,
  input  logic [15:0]     trig_value,
  input  logic [AW-1:0]   post_count,
  output logic            rd_valid,
  input  logic            rd_ready,
  output trace_rec_t      rd_data,
  output logic [1:0]      state,
  output logic            wrapped
);

  trace_state_t st_q;
  rd_phase_t    rd_phase_q;
  trig_mode_t   mode_q;
  logic [15:0]  tv_q;
  logic [AW-1:0] post_cnt_q;
  logic [AW-1:0] post_left;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   rd_left;
  logic [CYC_W-1:0] cyc_cnt;

  trace_rec_t    wr_rec;
  trace_rec_t    ram_q;
  logic          capture;
  logic          hit;
  logic          fire;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;

  assign capture = fetch_valid && (st_q == ST_ARMED || st_q == ST_POST);
  assign hit     = trig_hit(mode_q, tv_q, pc, ir);
  assign fire    = rd_valid && rd_ready;

  // On a handshake the following entry is read on the same edge so data streams back-to-back
  assign ram_re    = (st_q == ST_DONE) && ((rd_phase_q == RD_FETCH) || fire);
  assign ram_raddr = fire ? rd_ptr + AW'(1) : rd_ptr;

  assign wr_rec = '{cycle: TRACE_CYC_W'(cyc_cnt), pc: pc, sp: sp, ir: ir, flags: flags};

  assign rd_data = rd_valid ? ram_q : '0;
  assign state   = st_q;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_rec_t))
  ) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      rd_phase_q <= RD_SETUP;
      mode_q     <= TRIG_IMM;
      tv_q       <= '0;
      post_cnt_q <= '0;
      post_left  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_left    <= '0;
      rd_valid   <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (arm) begin
            st_q       <= ST_ARMED;
            rd_phase_q <= RD_SETUP;
            wr_ptr     <= '0;
            wrapped    <= 1'b0;
            mode_q     <= trig_mode_t'(trig_mode);
            tv_q       <= trig_value;
            post_cnt_q <= post_count;
          end
        end

        ST_ARMED, ST_POST: begin
          if (fetch_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_ptr == AW'(DEPTH - 1)) begin
              wrapped <= 1'b1;
            end
            if (st_q == ST_ARMED) begin
              if (hit) begin
                post_left <= post_cnt_q;
                st_q      <= (post_cnt_q == '0) ? ST_DONE : ST_POST;
              end
            end else begin
              post_left <= post_left - AW'(1);
              if (post_left == AW'(1)) begin
                st_q <= ST_DONE;
              end
            end
          end
        end

        ST_DONE: begin
          case (rd_phase_q)
            RD_SETUP: begin
              rd_ptr     <= wrapped ? wr_ptr : '0;
              rd_left    <= wrapped ? (AW+1)'(DEPTH) : {1'b0, wr_ptr};
              rd_phase_q <= RD_FETCH;
            end
            RD_FETCH: begin
              rd_valid   <= 1'b1;
              rd_phase_q <= RD_STREAM;
            end
            default: begin
              if (fire) begin
                if (rd_left == (AW+1)'(1)) begin
                  rd_valid <= 1'b0;
                  st_q     <= ST_IDLE;
                end else begin
                  rd_left <= rd_left - (AW+1)'(1);
                  rd_ptr  <= rd_ptr + AW'(1);
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
